fma_vector_checker: RTL

- Synthesizable, parametrised self-checking vector engine for FMA-class units (fma16 and wider successors).
- Fetches packed test vectors from a synchronous-read vector memory and drives the DUT operand and control ports.
- Waits a configurable DUT latency, then compares the DUT result and optionally its flags. Counts vectors and errors, reports the first-error detail, and signals done/pass.
- Sits between the vector ROM/RAM and the DUT in simulation and FPGA self-test harnesses.

---
 rtl/fma_vec_pkg.sv | 45 ++++
 rtl/fma_vec_unpack.sv | 38 +++
 rtl/fma_vector_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_vec_pkg.sv
// Shared constants for the FMA vector checker.
// Holds the FSM state encodings, the ctrl-field bit positions driven onto the
// DUT, and the helpers that locate each field inside a packed vector word.
// Word layout, MSB to LSB: {x, y, z, ctrl, expected, flagsexpected}.
package fma_vec_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Bit positions inside the ctrl field
  localparam int unsigned RM_HI = 5;
  localparam int unsigned RM_LO = 4;
  localparam int unsigned MUL   = 3;
  localparam int unsigned ADD   = 2;
  localparam int unsigned NEGP  = 1;
  localparam int unsigned NEGZ  = 0;

  // LSB offsets of each field within a vector word
  function automatic int unsigned off_exp(input int unsigned flagw);
    return flagw;
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned xlen, input int unsigned flagw);
    return flagw + xlen;
  endfunction

  function automatic int unsigned off_z(input int unsigned xlen, input int unsigned ctrlw,
                                        input int unsigned flagw);
    return flagw + xlen + ctrlw;
  endfunction

  function automatic int unsigned off_y(input int unsigned xlen, input int unsigned ctrlw,
                                        input int unsigned flagw);
    return off_z(xlen, ctrlw, flagw) + xlen;
  endfunction

  function automatic int unsigned off_x(input int unsigned xlen, input int unsigned ctrlw,
                                        input int unsigned flagw);
    return off_z(xlen, ctrlw, flagw) + 2 * xlen;
  endfunction

endpackage

// File: rtl/fma_vec_unpack.sv
// Combinational slicer of one packed vector word into its fields.
// Ports:
//   vec_data    in   packed word {x, y, z, ctrl, expected, flagsexpected}
//   x_c/y_c/z_c out  operands
//   ctrl_c      out  control field
//   expected_c  out  expected result
//   flags_c     out  expected flags
module fma_vec_unpack
  import fma_vec_pkg::*;
#(
  parameter int unsigned XLEN  = 16,
  parameter int unsigned CTRLW = 8,
  parameter int unsigned FLAGW = 4,
  parameter int unsigned VW    = 4 * XLEN + CTRLW + FLAGW
) (
  input  logic [VW-1:0]    vec_data,
  output logic [XLEN-1:0]  x_c,
  output logic [XLEN-1:0]  y_c,
  output logic [XLEN-1:0]  z_c,
  output logic [CTRLW-1:0] ctrl_c,
  output logic [XLEN-1:0]  expected_c,
  output logic [FLAGW-1:0] flags_c
);

  localparam int unsigned OFF_X    = off_x(XLEN, CTRLW, FLAGW);
  localparam int unsigned OFF_Y    = off_y(XLEN, CTRLW, FLAGW);
  localparam int unsigned OFF_Z    = off_z(XLEN, CTRLW, FLAGW);
  localparam int unsigned OFF_CTRL = off_ctrl(XLEN, FLAGW);
  localparam int unsigned OFF_EXP  = off_exp(FLAGW);

  assign x_c        = vec_data[OFF_X +: XLEN];
  assign y_c        = vec_data[OFF_Y +: XLEN];
  assign z_c        = vec_data[OFF_Z +: XLEN];
  assign ctrl_c     = vec_data[OFF_CTRL +: CTRLW];
  assign expected_c = vec_data[OFF_EXP +: XLEN];
  assign flags_c    = vec_data[FLAGW-1:0];

endmodule

// File: rtl/fma_vector_checker.sv
// Self-checking vector engine for FMA-class units.
// Walks a synchronous-read vector memory from address 0, drives each vector
// onto the DUT ports, waits LAT cycles, compares result (and optionally flags),
// and keeps vector/error counts plus the details of the first mismatch.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       begin a run from address 0 (ignored while busy)
//   flag_check_en, stop_on_err  compare flags / halt at first mismatch
//   vec_addr, vec_data, vec_valid  vector memory interface (1-cycle read)
//   dut_x/y/z, dut_roundmode, dut_mul/add/negp/negz  DUT stimulus
//   dut_result, dut_flags       DUT response
//   busy, done, pass            run status
//   vec_count, err_count        vectors checked, mismatches (saturating)
//   err_valid                   one-cycle pulse per mismatch
//   err_index/result/expected   first-mismatch detail
module fma_vector_checker
  import fma_vec_pkg::*;
#(
  parameter int unsigned XLEN  = 16,
  parameter int unsigned FLAGW = 4,
  parameter int unsigned CTRLW = 8,
  parameter int unsigned DEPTH = 10001,
  parameter int unsigned LAT   = 0,
  parameter int unsigned ADDRW = $clog2(DEPTH),
  parameter int unsigned VW    = 4 * XLEN + CTRLW + FLAGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flag_check_en,
  input  logic             stop_on_err,
  output logic [ADDRW-1:0] vec_addr,
  input  logic [VW-1:0]    vec_data,
  input  logic             vec_valid,
  output logic [XLEN-1:0]  dut_x,
  output logic [XLEN-1:0]  dut_y,
  output logic [XLEN-1:0]  dut_z,
  output logic [1:0]       dut_roundmode,
  output logic             dut_mul,
  output logic             dut_add,
  output logic             dut_negp,
  output logic             dut_negz,
  input  logic [XLEN-1:0]  dut_result,
  input  logic [FLAGW-1:0] dut_flags,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      vec_count,
  output logic [31:0]      err_count,
  output logic             err_valid,
  output logic [ADDRW-1:0] err_index,
  output logic [XLEN-1:0]  err_result,
  output logic [XLEN-1:0]  err_expected
);

  localparam int unsigned CNTW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  logic [2:0]       state, state_d;
  logic [CNTW-1:0]  wait_cnt, wait_cnt_d;
  logic [XLEN-1:0]  exp_q, exp_d;
  logic [FLAGW-1:0] flags_q, flags_d;

  logic [ADDRW-1:0] vec_addr_d, err_index_d;
  logic [XLEN-1:0]  dut_x_d, dut_y_d, dut_z_d, err_result_d, err_expected_d;
  logic [1:0]       dut_roundmode_d;
  logic             dut_mul_d, dut_add_d, dut_negp_d, dut_negz_d;
  logic             busy_d, done_d, pass_d, err_valid_d;
  logic [31:0]      vec_count_d, err_count_d;
  logic             mismatch_c;

  logic [XLEN-1:0]  x_c, y_c, z_c, expected_c;
  logic [CTRLW-1:0] ctrl_c;
  logic [FLAGW-1:0] flags_c;
  logic             unused_ctrl_c;

  fma_vec_unpack #(
    .XLEN (XLEN),
    .CTRLW(CTRLW),
    .FLAGW(FLAGW),
    .VW   (VW)
  ) u_unpack (
    .vec_data  (vec_data),
    .x_c       (x_c),
    .y_c       (y_c),
    .z_c       (z_c),
    .ctrl_c    (ctrl_c),
    .expected_c(expected_c),
    .flags_c   (flags_c)
  );

  // Upper ctrl bits are reserved and intentionally not driven anywhere
  assign unused_ctrl_c = ^ctrl_c;

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    wait_cnt_d      = wait_cnt;
    exp_d           = exp_q;
    flags_d         = flags_q;
    vec_addr_d      = vec_addr;
    dut_x_d         = dut_x;
    dut_y_d         = dut_y;
    dut_z_d         = dut_z;
    dut_roundmode_d = dut_roundmode;
    dut_mul_d       = dut_mul;
    dut_add_d       = dut_add;
    dut_negp_d      = dut_negp;
    dut_negz_d      = dut_negz;
    busy_d          = busy;
    done_d          = done;
    pass_d          = pass;
    vec_count_d     = vec_count;
    err_count_d     = err_count;
    err_valid_d     = 1'b0;
    err_index_d     = err_index;
    err_result_d    = err_result;
    err_expected_d  = err_expected;
    mismatch_c      = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_addr_d     = '0;
          vec_count_d    = '0;
          err_count_d    = '0;
          err_index_d    = '0;
          err_result_d   = '0;
          err_expected_d = '0;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          busy_d         = 1'b1;
          state_d        = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        if (!vec_valid) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count == '0);
          state_d = ST_DONE;
        end else begin
          dut_x_d         = x_c;
          dut_y_d         = y_c;
          dut_z_d         = z_c;
          dut_roundmode_d = ctrl_c[RM_HI:RM_LO];
          dut_mul_d       = ctrl_c[MUL];
          dut_add_d       = ctrl_c[ADD];
          dut_negp_d      = ctrl_c[NEGP];
          dut_negz_d      = ctrl_c[NEGZ];
          exp_d           = expected_c;
          flags_d         = flags_c;
          wait_cnt_d      = CNTW'(LAT);
          state_d         = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (wait_cnt != '0) begin
          wait_cnt_d = wait_cnt - CNTW'(1);
        end else begin
          // 4-state compare so an X/Z result is reported as a mismatch
          mismatch_c  = (dut_result !== exp_q) |
                        (flag_check_en & (dut_flags !== flags_q));
          vec_count_d = vec_count + 32'd1;
          if (mismatch_c) begin
            err_valid_d = 1'b1;
            if (err_count != '1) err_count_d = err_count + 32'd1;
            // Error detail only records the first mismatch of a run
            if (err_count == '0) begin
              err_index_d    = vec_addr;
              err_result_d   = dut_result;
              err_expected_d = exp_q;
            end
          end
          if ((stop_on_err && mismatch_c) || (vec_addr == ADDRW'(DEPTH - 1))) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            state_d = ST_DONE;
          end else begin
            vec_addr_d = vec_addr + ADDRW'(1);
            state_d    = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      exp_q         <= '0;
      flags_q       <= '0;
      vec_addr      <= '0;
      dut_x         <= '0;
      dut_y         <= '0;
      dut_z         <= '0;
      dut_roundmode <= '0;
      dut_mul       <= 1'b0;
      dut_add       <= 1'b0;
      dut_negp      <= 1'b0;
      dut_negz      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      err_index     <= '0;
      err_result    <= '0;
      err_expected  <= '0;
    end else begin
      state         <= state_d;
      wait_cnt      <= wait_cnt_d;
      exp_q         <= exp_d;
      flags_q       <= flags_d;
      vec_addr      <= vec_addr_d;
      dut_x         <= dut_x_d;
      dut_y         <= dut_y_d;
      dut_z         <= dut_z_d;
      dut_roundmode <= dut_roundmode_d;
      dut_mul       <= dut_mul_d;
      dut_add       <= dut_add_d;
      dut_negp      <= dut_negp_d;
      dut_negz      <= dut_negz_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      vec_count     <= vec_count_d;
      err_count     <= err_count_d;
      err_valid     <= err_valid_d;
      err_index     <= err_index_d;
      err_result    <= err_result_d;
      err_expected  <= err_expected_d;
    end
  end

endmodule
